// File: rtl/ex_stage.sv
// ex_stage: execute stage with ALU, HI/LO, store byte-lane steering and ID forwarding taps.
// Define EX_DIV_EN to build the 32-cycle radix-2 divider; without it div_op is ignored.
module ex_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [144:0] id_to_ex_bus,
    output logic [75:0]  ex_to_mem_bus,
    output logic [37:0]  ex_to_id,
    output logic         ex_is_load,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic         stallreq_for_ex
);
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO
    } alu_op_e;

    logic [144:0] ex_bus_r;
    logic [31:0]  pc, src1, src2, store_data;
    logic [3:0]   alu_op;
    logic [1:0]   mem_size, div_op;
    logic         mem_en, mem_we, rf_we, sel_rf_res;
    logic [4:0]   rf_waddr;

    logic [31:0]  hi_r, lo_r;
    logic [31:0]  ex_result, add_result;
    logic [3:0]   wen_store;
    logic         rf_we_eff;
    logic         div_done_wr;
    logic [31:0]  quo_final, rem_final;

    assign {pc, alu_op, src1, src2, mem_size, mem_en, mem_we, store_data,
            rf_we, rf_waddr, div_op, sel_rf_res} = ex_bus_r;

    always_ff @(posedge clk) begin
        if (rst)
            ex_bus_r <= '0;
        else if (stall[2] && !stall[3])
            ex_bus_r <= '0;
        else if (!stall[2])
            ex_bus_r <= id_to_ex_bus;
    end

    assign add_result = src1 + src2;

    always_comb begin
        ex_result = '0;
        case (alu_op)
            OP_ADD:  ex_result = add_result;
            OP_SUB:  ex_result = src1 - src2;
            OP_AND:  ex_result = src1 & src2;
            OP_OR:   ex_result = src1 | src2;
            OP_XOR:  ex_result = src1 ^ src2;
            OP_NOR:  ex_result = ~(src1 | src2);
            OP_SLT:  ex_result = {31'b0, $signed(src1) < $signed(src2)};
            OP_SLTU: ex_result = {31'b0, src1 < src2};
            OP_SLL:  ex_result = src2 << src1[4:0];
            OP_SRL:  ex_result = src2 >> src1[4:0];
            OP_SRA:  ex_result = $signed(src2) >>> src1[4:0];
            OP_LUI:  ex_result = {src2[15:0], 16'h0};
            OP_MFHI: ex_result = hi_r;
            OP_MFLO: ex_result = lo_r;
            default: ex_result = '0;
        endcase
    end

    always_comb begin
        wen_store       = 4'b0000;
        data_sram_wdata = store_data;
        case (mem_size)
            2'b00: begin
                wen_store       = 4'b0001 << add_result[1:0];
                data_sram_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                wen_store       = add_result[1] ? 4'b1100 : 4'b0011;
                data_sram_wdata = {2{store_data[15:0]}};
            end
            2'b10:   wen_store = 4'b1111;
            default: wen_store = 4'b0000;
        endcase
    end

    assign data_sram_en   = mem_en;
    assign data_sram_wen  = (mem_en && mem_we) ? wen_store : 4'b0000;
    assign data_sram_addr = add_result;
    assign ex_is_load     = mem_en & ~mem_we;

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;
    div_state_e  state, state_nxt;
    logic [31:0] quo_r, rem_r, dsr_r, dvd_abs, dsr_abs;
    logic [32:0] rem_shift, rem_diff;
    logic [4:0]  cnt_r;
    logic        neg_q_r, neg_r_r, div_valid, div_signed, rem_ge;
    logic        unused_ok;

    assign unused_ok  = ^{stall[5:4], stall[1:0]};
    assign div_valid  = (div_op == 2'b01) || (div_op == 2'b10);
    assign div_signed = (div_op == 2'b01);
    assign dvd_abs    = (div_signed && src1[31]) ? -src1 : src1;
    assign dsr_abs    = (div_signed && src2[31]) ? -src2 : src2;
    assign rem_shift  = {rem_r, quo_r[31]};
    assign rem_diff   = rem_shift - {1'b0, dsr_r};
    assign rem_ge     = rem_shift >= {1'b0, dsr_r};
    assign quo_final  = neg_q_r ? -quo_r : quo_r;
    assign rem_final  = neg_r_r ? -rem_r : rem_r;
    assign rf_we_eff  = rf_we & ~div_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (div_valid) state_nxt = (src2 == '0) ? DONE : BUSY;
            BUSY:    if (cnt_r == 5'd31) state_nxt = DONE;
            DONE:    if (!stall[2]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stallreq_for_ex = ((state == IDLE) && div_valid) || (state == BUSY);
        div_done_wr     = (state == DONE) && !stall[2];
    end

    // Zero divisor preloads the architectural result so DONE needs no special case.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_r   <= '0;
            rem_r   <= '0;
            dsr_r   <= '0;
            cnt_r   <= '0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (state == IDLE && div_valid) begin
            cnt_r <= '0;
            if (src2 == '0) begin
                quo_r   <= '1;
                rem_r   <= src1;
                neg_q_r <= 1'b0;
                neg_r_r <= 1'b0;
            end else begin
                quo_r   <= dvd_abs;
                rem_r   <= '0;
                dsr_r   <= dsr_abs;
                neg_q_r <= div_signed && (src1[31] ^ src2[31]);
                neg_r_r <= div_signed && src1[31];
            end
        end else if (state == BUSY) begin
            cnt_r <= cnt_r + 5'd1;
            rem_r <= rem_ge ? rem_diff[31:0] : rem_shift[31:0];
            quo_r <= {quo_r[30:0], rem_ge};
        end
    end
`else
    logic unused_ok;

    assign unused_ok       = ^{stall[5:4], stall[1:0], div_op};
    assign stallreq_for_ex = 1'b0;
    assign div_done_wr     = 1'b0;
    assign quo_final       = '0;
    assign rem_final       = '0;
    assign rf_we_eff       = rf_we;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (div_done_wr) begin
            hi_r <= rem_final;
            lo_r <= quo_final;
        end else if (!stall[2]) begin
            if (alu_op == OP_MTHI) hi_r <= src1;
            if (alu_op == OP_MTLO) lo_r <= src1;
        end
    end

    assign ex_to_mem_bus = {pc, data_sram_en, data_sram_wen, sel_rf_res,
                            rf_we_eff, rf_waddr, ex_result};
    assign ex_to_id      = {rf_we_eff, rf_waddr, ex_result};
endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; divider vectors are built only with EX_DIV_EN.
module tb_ex_stage;
    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [144:0] bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_id;
    logic         ex_is_load, data_sram_en, stallreq_for_ex;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_id        (ex_to_id),
        .ex_is_load      (ex_is_load),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .stallreq_for_ex (stallreq_for_ex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [75:0] got, input logic [75:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [144:0] mk(input logic [31:0] pc, input logic [3:0] op,
                                        input logic [31:0] s1, input logic [31:0] s2,
                                        input logic [1:0] msz, input logic men, input logic mwe,
                                        input logic [31:0] sd, input logic rfwe,
                                        input logic [4:0] wa, input logic [1:0] dop);
        return {pc, op, s1, s2, msz, men, mwe, sd, rfwe, wa, dop, 1'b0};
    endfunction

    function automatic logic [144:0] alu(input logic [3:0] op, input logic [31:0] s1,
                                         input logic [31:0] s2, input logic [4:0] wa);
        return mk(32'h0000_1000, op, s1, s2, 2'b00, 1'b0, 1'b0, '0, 1'b1, wa, 2'b00);
    endfunction

    logic [3:0]  t_op  [13] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                4'd8, 4'd9, 4'd10, 4'd11, 4'd0, 4'd6};
    logic [31:0] t_s1  [13] = '{32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4, 32'd4, 32'd4, 32'd0,
                                32'hFFFFFFFF, 32'd1};
    logic [31:0] t_s2  [13] = '{32'd7, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
                                32'd1, 32'd1, 32'd1, 32'h80000000, 32'h80000000, 32'hABCD1234,
                                32'd1, 32'hFFFFFFFF};
    logic [31:0] t_exp [13] = '{32'hFFFFFFFE, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0,
                                32'h000F000F, 32'd1, 32'd0, 32'd16, 32'h08000000,
                                32'hF8000000, 32'h12340000, 32'd0, 32'd0};

    logic [1:0]  s_sz   [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
    logic [31:0] s_off  [6] = '{32'd2, 32'd3, 32'd2, 32'd0, 32'd4, 32'd0};
    logic [31:0] s_data [6] = '{32'h000000AB, 32'h123456CD, 32'h0000BEEF, 32'h0000BEEF,
                                32'h12345678, 32'h12345678};
    logic [3:0]  s_wen  [6] = '{4'b0100, 4'b1000, 4'b1100, 4'b0011, 4'b1111, 4'b0000};
    logic [31:0] s_wd   [6] = '{32'hABABABAB, 32'hCDCDCDCD, 32'hBEEFBEEF, 32'hBEEFBEEF,
                                32'h12345678, 32'h0};

`ifdef EX_DIV_EN
    task automatic run_div(input string tag, input logic [1:0] dop, input logic [31:0] a,
                           input logic [31:0] b, input int exp_cyc,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int n;
        n = 0;
        stall = 6'b000000;
        bus = mk(32'h0000_2000, 4'd0, a, b, 2'b00, 1'b0, 1'b0, '0, 1'b1, 5'd7, dop);
        step();
        check({tag, "_rfwe"}, ex_to_id[37], 1'b0);
        bus = alu(4'd13, 32'd0, 32'd0, 5'd8);
        while (stallreq_for_ex && n < 100) begin
            stall = 6'b001111;
            step();
            n++;
        end
        check({tag, "_stall_cycles"}, n, exp_cyc);
        repeat (3) begin
            step();
            check({tag, "_done_hold"}, stallreq_for_ex, 1'b0);
        end
        stall = 6'b000000;
        step();
        check({tag, "_lo"}, ex_to_id[31:0], exp_lo);
        bus = alu(4'd12, 32'd0, 32'd0, 5'd8);
        step();
        check({tag, "_hi"}, ex_to_id[31:0], exp_hi);
    endtask
`endif

    initial begin
        rst   = 1'b1;
        stall = 6'b000000;
        bus   = mk(32'hDEAD_BEEF, 4'd0, 32'd1, 32'd2, 2'b10, 1'b1, 1'b1, 32'h55, 1'b1, 5'd9, 2'b00);
        step();
        step();
        check("rst_mem_bus", ex_to_mem_bus, '0);
        check("rst_to_id", ex_to_id, '0);
        check("rst_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, '0);
        check("rst_stallreq", {stallreq_for_ex, ex_is_load}, 2'b00);
        rst = 1'b0;

        bus = alu(4'd0, 32'd7, 32'd5, 5'd3);
        step();
        check("add_to_id", ex_to_id, {1'b1, 5'd3, 32'd12});
        check("add_mem_bus", ex_to_mem_bus, {32'h0000_1000, 1'b0, 4'b0000, 1'b0, 1'b1, 5'd3, 32'd12});

        for (int i = 0; i < 13; i++) begin
            bus = alu(t_op[i], t_s1[i], t_s2[i], 5'd1);
            step();
            check($sformatf("alu%0d_op%0d", i, t_op[i]), ex_to_id[31:0], t_exp[i]);
        end

        bus = alu(4'd14, 32'hAAAA5555, 32'd0, 5'd0);
        step();
        bus = alu(4'd12, 32'd0, 32'd0, 5'd2);
        step();
        check("mthi_mfhi", ex_to_id[31:0], 32'hAAAA5555);
        bus = alu(4'd15, 32'h12345678, 32'd0, 5'd0);
        step();
        bus = alu(4'd13, 32'd0, 32'd0, 5'd2);
        step();
        check("mtlo_mflo", ex_to_id[31:0], 32'h12345678);

        for (int i = 0; i < 6; i++) begin
            bus = mk(32'h0000_3000, 4'd0, 32'h0000_1000, s_off[i], s_sz[i], 1'b1, 1'b1,
                     s_data[i], 1'b0, 5'd0, 2'b00);
            step();
            check($sformatf("store%0d_wen", i), {data_sram_en, data_sram_wen, ex_to_mem_bus[43:39]},
                  {1'b1, s_wen[i], 1'b1, s_wen[i]});
            check($sformatf("store%0d_addr", i), data_sram_addr, 32'h0000_1000 + s_off[i]);
            if (s_sz[i] != 2'b11)
                check($sformatf("store%0d_wdata", i), data_sram_wdata, s_wd[i]);
        end
        bus = mk(32'h0000_3000, 4'd0, 32'h0000_1000, 32'd8, 2'b10, 1'b1, 1'b0, 32'hFFFF, 1'b1, 5'd4, 2'b00);
        step();
        check("load_sram", {data_sram_en, data_sram_wen, ex_is_load}, {1'b1, 4'b0000, 1'b1});

        bus = alu(4'd0, 32'd1, 32'd2, 5'd4);
        step();
        check("pre_bubble", ex_to_id, {1'b1, 5'd4, 32'd3});
        bus = alu(4'd0, 32'd10, 32'd20, 5'd5);
        stall = 6'b000100;
        step();
        check("bubble_mem_bus", ex_to_mem_bus, '0);
        stall = 6'b000000;
        step();
        check("after_bubble", ex_to_id, {1'b1, 5'd5, 32'd30});
        bus = alu(4'd0, 32'd100, 32'd1, 5'd6);
        stall = 6'b001100;
        step();
        check("hold_to_id", ex_to_id, {1'b1, 5'd5, 32'd30});
        stall = 6'b000000;

`ifdef EX_DIV_EN
        run_div("div_m7_2", 2'b01, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF);
        run_div("divu_9_0", 2'b10, 32'd9, 32'd0, 1, 32'hFFFFFFFF, 32'd9);
        run_div("divu_100_7", 2'b10, 32'd100, 32'd7, 33, 32'd14, 32'd2);
        run_div("div_7_m2", 2'b01, 32'd7, 32'hFFFFFFFE, 33, 32'hFFFFFFFD, 32'd1);
        run_div("divu_big", 2'b10, 32'hFFFFFFFF, 32'd2, 33, 32'h7FFFFFFF, 32'd1);

        bus = mk(32'h0000_4000, 4'd0, 32'd100, 32'd7, 2'b00, 1'b0, 1'b0, '0, 1'b1, 5'd7, 2'b01);
        step();
        stall = 6'b001111;
        repeat (10) step();
        check("busy_stallreq", stallreq_for_ex, 1'b1);
        rst = 1'b1;
        step();
        check("abort_stallreq", stallreq_for_ex, 1'b0);
        check("abort_to_id", ex_to_id, '0);
        rst   = 1'b0;
        stall = 6'b000000;
        bus   = alu(4'd12, 32'd0, 32'd0, 5'd1);
        step();
        check("abort_hi", ex_to_id[31:0], 32'd0);
        bus = alu(4'd13, 32'd0, 32'd0, 5'd1);
        step();
        check("abort_lo", ex_to_id[31:0], 32'd0);
`else
        bus = mk(32'h0000_4000, 4'd0, 32'd9, 32'd2, 2'b00, 1'b0, 1'b0, '0, 1'b1, 5'd9, 2'b01);
        step();
        check("nodiv_stallreq", stallreq_for_ex, 1'b0);
        check("nodiv_to_id", ex_to_id, {1'b1, 5'd9, 32'd11});
        bus = alu(4'd12, 32'd0, 32'd0, 5'd1);
        step();
        check("nodiv_hi", ex_to_id[31:0], 32'hAAAA5555);
        bus = alu(4'd13, 32'd0, 32'd0, 5'd1);
        step();
        check("nodiv_lo", ex_to_id[31:0], 32'h12345678);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
